pcie_cpl_tx_engine: RTL and testbench

//  Multi-DWORD completion TX engine for the PCIe DMA path. Builds 3DW-header Cpl/CplD TLPs onto the 64-bit
//  AXI-Stream TX port of the PCIe core, with payload of 1..MAX_DW DWORDs from a DMA response FIFO.

---
 rtl/pcie_cpl_tx_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_pcie_cpl_tx_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cpl_tx_engine.sv
// Completion TX engine: builds 3DW-header Cpl/CplD TLPs from a request and a
// DMA response FIFO onto a 64-bit AXI-Stream port. DMA faults become
// Completer-Abort completions and the faulted payload words are drained.
//
// Handshake semantics: every stream here is valid/ready. A transfer happens
// on the rising clock edge where valid and ready are both high. Once valid is
// raised, the producer holds the payload stable until that edge. Ready may
// toggle freely and never depends combinationally on valid.
module pcie_cpl_tx_engine #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = 8,
  parameter int MAX_DW       = 32,
  parameter int FIFO_LOG2    = 5
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0] o_s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   o_s_axis_tx_tkeep,
  output logic                    o_s_axis_tx_tlast,
  output logic                    o_s_axis_tx_tvalid,
  output logic                    o_tx_src_dsc,
  input  logic                    i_req_compl,
  input  logic                    i_req_compl_wd,
  input  logic [2:0]              i_req_tc,
  input  logic                    i_req_td,
  input  logic                    i_req_ep,
  input  logic [1:0]              i_req_attr,
  input  logic [9:0]              i_req_len,
  input  logic [15:0]             i_req_rid,
  input  logic [7:0]              i_req_tag,
  input  logic [12:0]             i_req_addr,
  input  logic [11:0]             i_req_bytes,
  input  logic                    i_dma_resp_valid,
  input  logic                    i_dma_resp_fault,
  input  logic [C_DATA_WIDTH-1:0] i_dma_resp_data,
  output logic                    o_dma_resp_ready,
  input  logic [15:0]             i_completer_id,
  output logic                    o_compl_done,
  output logic                    o_busy
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2+1)'(DEPTH);

  // Catch configurations the datapath cannot honour at elaboration time.
  if (C_DATA_WIDTH != 64 || KEEP_WIDTH != 8 || (MAX_DW / 2) > DEPTH) begin : g_bad_cfg
    $error("pcie_cpl_tx_engine: unsupported parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [63:0]             tdata_q, tdata_d;
  logic [7:0]              tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic [9:0]              rem_q, rem_d;       // payload DWs not yet loaded into a beat
  logic [9:0]              flush_q, flush_d;   // faulted words still to discard
  logic [31:0]             held_q, held_d;     // upper DW of the last popped word
  logic                    cpl_q, cpl_d;       // header-only completion (Cpl or abort)
  logic [15:0]             rid_q, rid_d;
  logic [7:0]              tag_q, tag_d;
  logic [6:0]              laddr_q, laddr_d;
  logic                    run_q, run_d;
  logic [FIFO_LOG2-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]      count_q, count_d;
  logic [64:0]             mem_q [DEPTH];

  logic                    hs, pop, pop_ok, push, ready_int, can_start;
  logic                    req_flt, flt_eff, is_cpl;
  logic [9:0]              req_nw;
  logic [63:0]             head, beat0;
  logic [FIFO_LOG2-1:0]    idx;
  logic                    unused_addr;

  assign unused_addr = ^i_req_addr[12:7];
  assign hs   = tvalid_q && i_s_axis_tx_tready;
  assign head = mem_q[rd_ptr_q][63:0];

  // Word count needed and fault OR over the first NW queued entries.
  always_comb begin
    req_nw  = {1'b0, i_req_len[9:1]} + {9'd0, i_req_len[0]};
    req_flt = 1'b0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + i[FIFO_LOG2-1:0];
      if (i < int'(req_nw)) req_flt = req_flt | mem_q[idx][64];
    end
    flt_eff   = i_req_compl_wd && req_flt;
    is_cpl    = !i_req_compl_wd || req_flt;
    can_start = i_req_compl && (!i_req_compl_wd || 32'(count_q) >= 32'(req_nw));
    beat0 = {i_completer_id, (flt_eff ? 3'b100 : 3'b000), 1'b0, i_req_bytes,
             1'b0, (is_cpl ? 7'h0A : 7'h4A), 1'b0, i_req_tc, 4'b0000,
             i_req_td, i_req_ep | flt_eff, i_req_attr, 2'b00,
             (is_cpl ? 10'd0 : i_req_len)};
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    run_d     = 1'b1;
    ready_int = run_q && (count_q < DEPTH_C);
    push      = i_dma_resp_valid && ready_int;
    pop_ok    = pop && (count_q != '0);
    wr_ptr_d  = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push && pop_ok) count_d = count_q - 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:         if (can_start) state_d = S_HDR0;
      S_HDR0:         if (hs) state_d = S_HDR1;
      S_HDR1, S_DATA: if (hs) state_d = tlast_q ? S_DONE : S_DATA;
      S_DONE:         if (flush_q == '0) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Beat construction, FIFO pops and per-packet counters.
  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    rem_d    = rem_q;
    flush_d  = flush_q;
    held_d   = held_q;
    cpl_d    = cpl_q;
    rid_d    = rid_q;
    tag_d    = tag_q;
    laddr_d  = laddr_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: if (can_start) begin
        tvalid_d = 1'b1;
        tdata_d  = beat0;
        tkeep_d  = 8'hFF;
        tlast_d  = 1'b0;
        cpl_d    = is_cpl;
        rem_d    = is_cpl ? 10'd0 : i_req_len;
        flush_d  = flt_eff ? req_nw : 10'd0;
        rid_d    = i_req_rid;
        tag_d    = i_req_tag;
        laddr_d  = is_cpl ? 7'd0 : i_req_addr[6:0];
      end
      S_HDR0: if (hs) begin
        if (cpl_q) begin
          tdata_d = {32'h0, rid_q, tag_q, 1'b0, laddr_q};
          tkeep_d = 8'h0F;
          tlast_d = 1'b1;
        end else begin
          pop     = 1'b1;
          tdata_d = {head[31:0], rid_q, tag_q, 1'b0, laddr_q};
          held_d  = head[63:32];
          tkeep_d = 8'hFF;
          tlast_d = (rem_q == 10'd1);
          rem_d   = rem_q - 10'd1;
        end
      end
      S_HDR1, S_DATA: if (hs) begin
        if (tlast_q) begin
          tvalid_d = 1'b0;
          tdata_d  = '0;
          tkeep_d  = '0;
          tlast_d  = 1'b0;
        end else if (rem_q == 10'd1) begin
          tdata_d = {32'h0, held_q};
          tkeep_d = 8'h0F;
          tlast_d = 1'b1;
          rem_d   = 10'd0;
        end else begin
          pop     = 1'b1;
          tdata_d = {head[31:0], held_q};
          held_d  = head[63:32];
          tkeep_d = 8'hFF;
          tlast_d = (rem_q == 10'd2);
          rem_d   = rem_q - 10'd2;
        end
      end
      S_DONE: if (flush_q != '0) begin
        pop     = 1'b1;
        flush_d = flush_q - 10'd1;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset abandons any packet and empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q  <= S_IDLE;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      rem_q    <= '0;
      flush_q  <= '0;
      held_q   <= '0;
      cpl_q    <= 1'b0;
      rid_q    <= '0;
      tag_q    <= '0;
      laddr_q  <= '0;
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      rem_q    <= rem_d;
      flush_q  <= flush_d;
      held_q   <= held_d;
      cpl_q    <= cpl_d;
      rid_q    <= rid_d;
      tag_q    <= tag_d;
      laddr_q  <= laddr_d;
      run_q    <= run_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_dma_resp_fault, i_dma_resp_data};
  end

  assign o_s_axis_tx_tdata  = tdata_q;
  assign o_s_axis_tx_tkeep  = tkeep_q;
  assign o_s_axis_tx_tlast  = tlast_q;
  assign o_s_axis_tx_tvalid = tvalid_q;
  assign o_tx_src_dsc       = 1'b0;
  assign o_dma_resp_ready   = ready_int;
  assign o_compl_done       = (state_q == S_DONE) && (flush_q == '0);
  assign o_busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcie_cpl_tx_engine.sv
// Bench for pcie_cpl_tx_engine: directed completions with a beat scoreboard.
module tb_pcie_cpl_tx_engine;

  localparam int FIFO_LOG2 = 4;
  localparam int DEPTH     = 1 << FIFO_LOG2;
  localparam logic [15:0] CID = 16'h0100;

  logic        clk = 1'b0;
  logic        i_nrst;
  logic        i_s_axis_tx_tready;
  logic [63:0] o_s_axis_tx_tdata;
  logic [7:0]  o_s_axis_tx_tkeep;
  logic        o_s_axis_tx_tlast, o_s_axis_tx_tvalid, o_tx_src_dsc;
  logic        i_req_compl, i_req_compl_wd, i_req_td, i_req_ep;
  logic [2:0]  i_req_tc;
  logic [1:0]  i_req_attr;
  logic [9:0]  i_req_len;
  logic [15:0] i_req_rid;
  logic [7:0]  i_req_tag;
  logic [12:0] i_req_addr;
  logic [11:0] i_req_bytes;
  logic        i_dma_resp_valid, i_dma_resp_fault;
  logic [63:0] i_dma_resp_data;
  logic        o_dma_resp_ready, o_compl_done, o_busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tready_mode = 0;
  logic [72:0] exp_q[$];
  logic [31:0] dw_arr [0:63];

  pcie_cpl_tx_engine #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8), .MAX_DW(32), .FIFO_LOG2(FIFO_LOG2)) dut (
    .i_clk(clk), .i_nrst(i_nrst), .i_s_axis_tx_tready(i_s_axis_tx_tready),
    .o_s_axis_tx_tdata(o_s_axis_tx_tdata), .o_s_axis_tx_tkeep(o_s_axis_tx_tkeep),
    .o_s_axis_tx_tlast(o_s_axis_tx_tlast), .o_s_axis_tx_tvalid(o_s_axis_tx_tvalid),
    .o_tx_src_dsc(o_tx_src_dsc), .i_req_compl(i_req_compl), .i_req_compl_wd(i_req_compl_wd),
    .i_req_tc(i_req_tc), .i_req_td(i_req_td), .i_req_ep(i_req_ep), .i_req_attr(i_req_attr),
    .i_req_len(i_req_len), .i_req_rid(i_req_rid), .i_req_tag(i_req_tag),
    .i_req_addr(i_req_addr), .i_req_bytes(i_req_bytes),
    .i_dma_resp_valid(i_dma_resp_valid), .i_dma_resp_fault(i_dma_resp_fault),
    .i_dma_resp_data(i_dma_resp_data), .o_dma_resp_ready(o_dma_resp_ready),
    .i_completer_id(CID), .o_compl_done(o_compl_done), .o_busy(o_busy)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // tready driver: 0 = always ready, 1 = toggle, 2 = random
  initial begin
    i_s_axis_tx_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0:       i_s_axis_tx_tready = 1'b1;
        1:       i_s_axis_tx_tready = ~i_s_axis_tx_tready;
        default: i_s_axis_tx_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops expected beats on handshake, checks stability while stalled
  initial begin
    logic [72:0] beat, stall_beat, e;
    logic stall_v;
    stall_v = 1'b0;
    stall_beat = '0;
    forever begin
      @(negedge clk);
      if (i_nrst && o_s_axis_tx_tvalid) begin
        beat = {o_s_axis_tx_tlast, o_s_axis_tx_tkeep, o_s_axis_tx_tdata};
        if (stall_v) chk("stall_hold", beat, stall_beat);
        if (i_s_axis_tx_tready) begin
          stall_v = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat got %h want none", beat);
          end else begin
            e = exp_q.pop_front();
            chk("beat", beat, e);
          end
        end else begin
          stall_v = 1'b1;
          stall_beat = beat;
        end
      end else begin
        stall_v = 1'b0;
      end
      if (i_nrst && o_compl_done) done_cnt++;
    end
  end

  task automatic push_exp(input logic last, input logic [7:0] keep, input logic [63:0] data);
    exp_q.push_back({last, keep, data});
  endtask

  task automatic push_word(input logic [63:0] d, input logic f);
    int n = 0;
    @(posedge clk); #1;
    i_dma_resp_valid = 1'b1; i_dma_resp_data = d; i_dma_resp_fault = f;
    while (!o_dma_resp_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL push_timeout got ready=0 want ready=1");
    end
    @(posedge clk); #1;
    i_dma_resp_valid = 1'b0;
  endtask

  // Pushes the words holding dw_arr[0..len-1] with no fault
  task automatic push_dws(input int len);
    for (int k = 0; k < (len + 1) / 2; k++) push_word({dw_arr[2*k+1], dw_arr[2*k]}, 1'b0);
  endtask

  task automatic start_req(input logic wd, input logic [9:0] len, input logic [2:0] tc,
                           input logic td, input logic ep, input logic [1:0] attr,
                           input logic [15:0] rid, input logic [7:0] tag,
                           input logic [12:0] addr, input logic [11:0] bytes);
    @(posedge clk); #1;
    i_req_compl_wd = wd; i_req_len = len; i_req_tc = tc; i_req_td = td; i_req_ep = ep;
    i_req_attr = attr; i_req_rid = rid; i_req_tag = tag; i_req_addr = addr; i_req_bytes = bytes;
    i_req_compl = 1'b1;
  endtask

  // Reference packing of a clean CplD: header then DWs two per beat
  task automatic expect_cpld(input int len, input logic [2:0] tc, input logic td,
                             input logic ep, input logic [1:0] attr, input logic [15:0] rid,
                             input logic [7:0] tag, input logic [12:0] addr,
                             input logic [11:0] bytes);
    logic [9:0] l10;
    int i;
    l10 = 10'(len);
    push_exp(1'b0, 8'hFF, {CID, 3'b000, 1'b0, bytes, 1'b0, 7'h4A, 1'b0, tc, 4'b0, td, ep,
                          attr, 2'b00, l10});
    push_exp(len == 1, 8'hFF, {dw_arr[0], rid, tag, 1'b0, addr[6:0]});
    i = 1;
    while (i < len) begin
      if (i + 1 < len) push_exp(i + 2 >= len, 8'hFF, {dw_arr[i+1], dw_arr[i]});
      else             push_exp(1'b1, 8'h0F, {32'h0, dw_arr[i]});
      i += 2;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_compl_done && n < 2000);
    checks++;
    if (!o_compl_done) begin
      errors++;
      $display("FAIL %s_done_timeout got 0 want 1", name);
    end
    i_req_compl = 1'b0;
    chk({name, "_queue_empty"}, 73'(exp_q.size()), 73'd0);
    @(negedge clk);
    chk({name, "_done_busy_after"}, {71'd0, o_compl_done, o_busy}, 73'd0);
  endtask

  task automatic fill_dw(input int len, input logic [31:0] base);
    for (int k = 0; k < 64; k++) dw_arr[k] = (k < len) ? base + 32'(k) : 32'hBAD0_0000;
  endtask

  initial begin
    i_nrst = 1'b0; i_req_compl = 1'b0; i_req_compl_wd = 1'b0; i_req_tc = '0; i_req_td = 1'b0;
    i_req_ep = 1'b0; i_req_attr = '0; i_req_len = '0; i_req_rid = '0; i_req_tag = '0;
    i_req_addr = '0; i_req_bytes = '0; i_dma_resp_valid = 1'b0; i_dma_resp_fault = 1'b0;
    i_dma_resp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_s_axis_tx_tdata, o_s_axis_tx_tkeep, o_s_axis_tx_tlast},
        73'd0);
    chk("reset_flags", {68'd0, o_s_axis_tx_tvalid, o_tx_src_dsc, o_dma_resp_ready,
                        o_compl_done, o_busy}, 73'd0);
    i_nrst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {72'd0, o_dma_resp_ready}, 73'd1);

    // 1: CplD len=1, lower address 0x44
    push_word(64'hDEAD_BEEF_1122_3344, 1'b0);
    push_exp(1'b0, 8'hFF, 64'h0100_0004_4A00_0001);
    push_exp(1'b1, 8'hFF, 64'h1122_3344_00AB_1244);
    start_req(1'b1, 10'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h00AB, 8'h12, 13'h044, 12'h004);
    wait_done("t1");

    // 2: CplD len=4 with words {2,1},{4,3}
    fill_dw(4, 32'h1);
    push_dws(4);
    expect_cpld(4, 3'd1, 1'b0, 1'b0, 2'd0, 16'h0102, 8'h22, 13'h000, 12'h010);
    start_req(1'b1, 10'd4, 3'd1, 1'b0, 1'b0, 2'd0, 16'h0102, 8'h22, 13'h000, 12'h010);
    wait_done("t2");

    // 3: Cpl without data
    push_exp(1'b0, 8'hFF, 64'h0100_0004_0A20_9000);
    push_exp(1'b1, 8'h0F, 64'h0000_0000_0203_0500);
    start_req(1'b0, 10'd1, 3'd2, 1'b1, 1'b0, 2'd1, 16'h0203, 8'h05, 13'h044, 12'h004);
    wait_done("t3");

    // 4: CplD len=3 with faulted second word -> Completer Abort
    push_word(64'h0000_0B0B_0000_0A0A, 1'b0);
    push_word(64'h0000_0D0D_0000_0C0C, 1'b1);
    push_exp(1'b0, 8'hFF, 64'h0100_800C_0A00_4000);
    push_exp(1'b1, 8'h0F, 64'h0000_0000_0304_0600);
    start_req(1'b1, 10'd3, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0304, 8'h06, 13'h010, 12'h00C);
    wait_done("t4");

    // 4b: FIFO drained by abort, next CplD sees only fresh data
    fill_dw(2, 32'h5000);
    push_dws(2);
    expect_cpld(2, 3'd0, 1'b0, 1'b0, 2'd2, 16'h0405, 8'h07, 13'h07C, 12'h008);
    start_req(1'b1, 10'd2, 3'd0, 1'b0, 1'b0, 2'd2, 16'h0405, 8'h07, 13'h07C, 12'h008);
    wait_done("t4b");

    // 5: len=8 with tready high, then toggled, then random with len=5 and EP echoed
    for (int m = 0; m < 3; m++) begin
      int len;
      tready_mode = m;
      len = (m == 2) ? 5 : 8;
      fill_dw(len, 32'h7000 + 32'(m) * 32'h100);
      push_dws(len);
      expect_cpld(len, 3'd7, 1'b1, m == 2, 2'd3, 16'h0506, 8'h30 + 8'(m), 13'h033, 12'h020);
      start_req(1'b1, 10'(len), 3'd7, 1'b1, m == 2, 2'd3, 16'h0506, 8'h30 + 8'(m),
                13'h033, 12'h020);
      wait_done("t5");
    end

    // 6: fill FIFO to depth, then drain with a full-size CplD
    tready_mode = 0;
    fill_dw(2 * DEPTH, 32'hA000);
    push_dws(2 * DEPTH);
    chk("fifo_full_ready", {72'd0, o_dma_resp_ready}, 73'd0);
    expect_cpld(2 * DEPTH, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0607, 8'h40, 13'h000, 12'h080);
    start_req(1'b1, 10'(2 * DEPTH), 3'd0, 1'b0, 1'b0, 2'd0, 16'h0607, 8'h40, 13'h000, 12'h080);
    wait_done("t6");
    chk("fifo_drained_ready", {72'd0, o_dma_resp_ready}, 73'd1);

    // 7: reset in the middle of a packet
    tready_mode = 1;
    fill_dw(2 * DEPTH, 32'hC000);
    push_dws(2 * DEPTH);
    expect_cpld(2 * DEPTH, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0708, 8'h50, 13'h000, 12'h080);
    start_req(1'b1, 10'(2 * DEPTH), 3'd0, 1'b0, 1'b0, 2'd0, 16'h0708, 8'h50, 13'h000, 12'h080);
    repeat (8) @(posedge clk);
    #1;
    i_nrst = 1'b0;
    i_req_compl = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midreset_flags", {70'd0, o_s_axis_tx_tvalid, o_dma_resp_ready, o_busy}, 73'd0);
    @(posedge clk); #1;
    i_nrst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ready", {72'd0, o_dma_resp_ready}, 73'd1);
    tready_mode = 0;

    // 8: FIFO flushed by reset, fresh CplD len=3 returns only new data
    fill_dw(3, 32'hE000);
    push_dws(3);
    expect_cpld(3, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0809, 8'h60, 13'h005, 12'h00C);
    start_req(1'b1, 10'd3, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0809, 8'h60, 13'h005, 12'h00C);
    wait_done("t8");

    chk("done_pulse_count", 73'(done_cnt), 73'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
